// File: rtl/conv_mc.sv
// Multi-channel 2-D convolution engine: one KHxKW window per channel per cycle,
// bias + requantise + saturate. Define CONV_MC_RELU_EN for unsigned ReLU output.
//
//   state  | meaning
//   IDLE   | waiting for start
//   ACCUM  | adding one channel's window dot product per cycle
//   OUTPUT | result presented, waiting for out_ready
//   FINISH | one-cycle done pulse after the last pixel
module conv_mc #(
    parameter int IFMAP_HEIGHT  = 8,
    parameter int IFMAP_WIDTH   = 8,
    parameter int IN_CHANNELS   = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int KERNEL_WIDTH  = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int H_STRIDE      = 1,
    parameter int V_STRIDE      = 1,
    parameter int PADDING       = 0,
    parameter int SHIFT         = 0,
    localparam int OFMAP_HEIGHT = (IFMAP_HEIGHT + 2*PADDING - KERNEL_HEIGHT) / V_STRIDE + 1,
    localparam int OFMAP_WIDTH  = (IFMAP_WIDTH + 2*PADDING - KERNEL_WIDTH) / H_STRIDE + 1,
    localparam int ROW_W        = (OFMAP_HEIGHT > 1) ? $clog2(OFMAP_HEIGHT) : 1,
    localparam int COL_W        = (OFMAP_WIDTH > 1) ? $clog2(OFMAP_WIDTH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic        [DATA_WIDTH-1:0]   ifmap   [IN_CHANNELS][IFMAP_HEIGHT][IFMAP_WIDTH],
    input  logic signed [DATA_WIDTH-1:0]   weights [IN_CHANNELS][KERNEL_HEIGHT][KERNEL_WIDTH],
    input  logic signed [2*DATA_WIDTH-1:0] bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic        [DATA_WIDTH-1:0]   out_data,
    output logic        [ROW_W-1:0]        out_row,
    output logic        [COL_W-1:0]        out_col,
    output logic                           busy,
    output logic                           done
);
    localparam int ACC_W = 2*DATA_WIDTH + $clog2(KERNEL_HEIGHT*KERNEL_WIDTH*IN_CHANNELS) + 1;
    localparam int CH_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int IH_W  = (IFMAP_HEIGHT > 1) ? $clog2(IFMAP_HEIGHT) : 1;
    localparam int IW_W  = (IFMAP_WIDTH > 1) ? $clog2(IFMAP_WIDTH) : 1;

`ifdef CONV_MC_RELU_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**DATA_WIDTH) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = '0;
`else
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2**(DATA_WIDTH-1)));
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT, FINISH} state_t;

    state_t                  state_q;
    logic [ROW_W-1:0]        row_q;
    logic [COL_W-1:0]        col_q;
    logic [CH_W-1:0]         ch_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] dot_d;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] res_d;
    logic signed [ACC_W-1:0] bias_ext;
    logic [DATA_WIDTH-1:0]   sat_d;
    logic                    last_ch;
    logic                    last_col;
    logic                    last_pix;

    // Window taps that land in the padding ring are simply skipped.
    always_comb begin
        int ir;
        int ic;
        dot_d = '0;
        ir    = 0;
        ic    = 0;
        for (int kh = 0; kh < KERNEL_HEIGHT; kh++) begin
            for (int kw = 0; kw < KERNEL_WIDTH; kw++) begin
                ir = int'(row_q) * V_STRIDE + kh - PADDING;
                ic = int'(col_q) * H_STRIDE + kw - PADDING;
                if (ir >= 0 && ir < IFMAP_HEIGHT && ic >= 0 && ic < IFMAP_WIDTH) begin
                    dot_d = dot_d + ACC_W'($signed({1'b0, ifmap[ch_q][ir[IH_W-1:0]][ic[IW_W-1:0]]})
                                           * weights[ch_q][kh][kw]);
                end
            end
        end
    end

    assign acc_d    = acc_q + dot_d;
    assign res_d    = acc_d >>> SHIFT;
    assign bias_ext = ACC_W'(bias);
    assign last_ch  = (ch_q == CH_W'(IN_CHANNELS - 1));
    assign last_col = (col_q == COL_W'(OFMAP_WIDTH - 1));
    assign last_pix = last_col && (row_q == ROW_W'(OFMAP_HEIGHT - 1));
    assign out_row  = row_q;
    assign out_col  = col_q;

    always_comb begin
        if (res_d > SAT_HI)
            sat_d = SAT_HI[DATA_WIDTH-1:0];
        else if (res_d < SAT_LO)
            sat_d = SAT_LO[DATA_WIDTH-1:0];
        else
            sat_d = res_d[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            ch_q      <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        ch_q    <= '0;
                        acc_q   <= bias_ext;
                        busy    <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (last_ch) begin
                        ch_q      <= '0;
                        out_data  <= sat_d;
                        out_valid <= 1'b1;
                        state_q   <= OUTPUT;
                    end else begin
                        ch_q <= ch_q + CH_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc_q     <= bias_ext;
                        if (last_pix) begin
                            done    <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            state_q <= ACCUM;
                            if (last_col) begin
                                col_q <= '0;
                                row_q <= row_q + ROW_W'(1);
                            end else begin
                                col_q <= col_q + COL_W'(1);
                            end
                        end
                    end
                end
                FINISH: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
